keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Emulates the 4x4 matrix keypad on the far end of the scanned row/column interface.
- Watches the active-low one-hot `column` drive and returns active-low `row` sense lines as if a physical key were held.
- Key presses are requested over a valid/ready command port. Used in simulation benches and in the on-board self-test path to inject keystrokes into the keypad scanner without a physical keypad.

Parameters:
- HOLD_SCANS, 2, full scan periods the key is held pressed (legal 1..255).
- RELEASE_SCANS, 2, full scan periods of guaranteed release after a press (legal 1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- column  in  4  active-low one-hot column drive from the scanner; 4'b1111 = idle slot.
- row  out  4  active-low row sense lines.
- key_code  in  4  requested key: 0-9, A, C, E.
- key_valid  in  1  command request.
- key_ready  out  1  emulator can accept a command (high only in IDLE).
- busy  out  1  press/release sequence in progress.
- done  out  1  one-cycle pulse when the release phase ends.
- bad_key  out  1  one-cycle pulse when an unmapped code (B, D, F) is offered.

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE, row = 4'b1111, key_ready = 1, busy = 0, done = 0, bad_key = 0, scan counter = 0, held key cleared.
- Key map, given as (column index, row index); index 0 = LSB low:
  - col0: 1 (r0), 4 (r1), 7 (r2), 0 (r3).
  - col1: 2 (r0), 5 (r1), 8 (r2).
  - col2: 3 (r0), 6 (r1), 9 (r2), E (r3).
  - col3: A (r0), C (r2).
- Row drive:
  - `row` is combinational from `column` and the registered pressed key, so the scanner sees the response in the same cycle.
  - When pressed and `column` equals exactly the held key's column pattern, the held key's row bit is 0; otherwise `row` = 4'b1111.
  - Any column value that is not one-hot-low (0 or ≥2 bits low) gives `row` = 4'b1111.
- Scan boundary: `scan_tick` fires for one cycle when `column` becomes 4'b1111 having been non-1111 on the previous cycle. The previous-column value is registered.
- Command handshake:
  - Accept on key_valid & key_ready in IDLE; the code is captured that cycle.
  - If the code is unmapped: bad_key pulses the next cycle, state stays IDLE, nothing is pressed.
- States:
  - IDLE: key_ready = 1. Valid accept -> SYNC.
  - SYNC: waits for the next scan_tick so the press begins at a scan start -> PRESS, counter = 0. Pressed flag is set on the transition.
  - PRESS: counter increments per scan_tick. At the HOLD_SCANS-th tick: clear pressed -> RELEASE, counter = 0.
  - RELEASE: counter increments per scan_tick. At the RELEASE_SCANS-th tick: done pulses -> IDLE.
- busy = 1 in SYNC, PRESS and RELEASE. key_ready = ~busy.
- Counter is 8 bits with no wrap in legal use; it is compared with ==, never >=.
- Boundary conditions:
  - key_valid held high through done: the next command is accepted on the first IDLE cycle, which is the cycle after the done pulse. The mandatory RELEASE phase guarantees the scanner sees a release between repeated identical keys.
  - key_code changing while busy: ignored.
  - Scanner stalled (column constant): the state is held indefinitely; there is no timeout.
  - Async reset mid-PRESS: row returns to 4'b1111 immediately, without waiting for a clock.

Decomposition:
- Shared package `keypad_pkg`:
  - Enumerated state type (IDLE, SYNC, PRESS, RELEASE).
  - Key-code constants KEY_A = 4'hA, KEY_C = 4'hC, KEY_E = 4'hE.
  - Column/row one-hot-low constants.
  - A function mapping a 4-bit key code to {valid, column index, row index}.
- One natural sub-module, `scan_edge_detect`: registers `column` and emits `scan_tick`.

Test Plan:
- Paired with the keypad scanner as DUT. Command key_code = 5, defaults -> after HOLD_SCANS scans the scanner outputs digit = 5 with exactly one valid pulse; done pulses after 2 further scan_ticks.
- Command sequence 1, 1, E -> the scanner reports three valid pulses with digits 1, 1, E. None are missed, which confirms the release gap between repeated keys.
- key_code = B with key_valid -> bad_key pulses once, key_ready stays 1, row stays 4'b1111 across 10 scans.
- Standalone: pressed key A, column = 4'b1110 -> row = 4'b1111. column = 4'b0111 -> row = 4'b1110. column = 4'b0011 -> row = 4'b1111, in the same cycle each time.
- Assert reset low mid-PRESS holding key 0 with column = 4'b1110 -> row = 4'b1111 before the next clk edge. After release: key_ready = 1, busy = 0.
- column frozen at 4'b1101 after accept -> state remains SYNC, busy = 1, done never pulses over 1000 cycles.

Source files
------------

// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg : shared types, key codes and the key-to-matrix map
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SYNC    = 2'd1,
      ST_PRESS   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_E    = 4'hE;
   localparam logic [3:0] COL_IDLE = 4'b1111;
   localparam logic [3:0] ROW_IDLE = 4'b1111;

   typedef struct packed {
      logic       valid;
      logic [1:0] col;
      logic [1:0] row;
   } key_loc_t;

   function automatic logic [3:0] onehot_low(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // B, D and F have no key on this pad and come back with valid = 0
   function automatic key_loc_t key_map(input logic [3:0] code);
      key_loc_t loc;
      loc = '{valid: 1'b1, col: 2'd0, row: 2'd0};
      case (code)
         4'h1:    begin loc.col = 2'd0; loc.row = 2'd0; end
         4'h4:    begin loc.col = 2'd0; loc.row = 2'd1; end
         4'h7:    begin loc.col = 2'd0; loc.row = 2'd2; end
         4'h0:    begin loc.col = 2'd0; loc.row = 2'd3; end
         4'h2:    begin loc.col = 2'd1; loc.row = 2'd0; end
         4'h5:    begin loc.col = 2'd1; loc.row = 2'd1; end
         4'h8:    begin loc.col = 2'd1; loc.row = 2'd2; end
         4'h3:    begin loc.col = 2'd2; loc.row = 2'd0; end
         4'h6:    begin loc.col = 2'd2; loc.row = 2'd1; end
         4'h9:    begin loc.col = 2'd2; loc.row = 2'd2; end
         KEY_E:   begin loc.col = 2'd2; loc.row = 2'd3; end
         KEY_A:   begin loc.col = 2'd3; loc.row = 2'd0; end
         KEY_C:   begin loc.col = 2'd3; loc.row = 2'd2; end
         default: loc.valid = 1'b0;
      endcase
      return loc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/scan_edge_detect.sv
// ----------------------------------------------------------------------------
// scan_edge_detect : one-cycle tick when the column drive enters the idle slot
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scan_edge_detect
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_column,
   output logic       o_scan_tick
);

   logic [3:0] r_col_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col_prev <= COL_IDLE;
      end else begin
         r_col_prev <= i_column;
      end
   end

   assign o_scan_tick = (i_column == COL_IDLE) && (r_col_prev != COL_IDLE);

endmodule

`default_nettype wire

// File: rtl/keypad_emulator.sv
// ----------------------------------------------------------------------------
// keypad_emulator : answers a row/column scanner as if a requested key is held
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_SCANS    = 2,
   parameter int RELEASE_SCANS = 2
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] column,
   output logic [3:0] row,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   output logic       busy,
   output logic       done,
   output logic       bad_key
);

   localparam logic [7:0] c_HOLD_SCANS    = 8'(HOLD_SCANS);
   localparam logic [7:0] c_RELEASE_SCANS = 8'(RELEASE_SCANS);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_pressed;
   logic [1:0] r_col_idx;
   logic [1:0] r_row_idx;
   logic       r_busy;
   logic       r_done;
   logic       r_bad;

   logic       w_scan_tick;
   logic       w_accept;
   logic [7:0] w_cnt_next;
   key_loc_t   w_loc;

   scan_edge_detect u_scan_edge_detect (
      .clk         (clk),
      .reset       (reset),
      .i_column    (column),
      .o_scan_tick (w_scan_tick)
   );

   assign w_loc      = key_map(key_code);
   assign w_accept   = key_valid && !r_busy;
   assign w_cnt_next = r_cnt + 8'd1;

   // Same-cycle response: the scanner samples rows while it drives the column
   always_comb begin
      row = ROW_IDLE;
      if (r_pressed && (column == onehot_low(r_col_idx))) begin
         row = onehot_low(r_row_idx);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 8'd0;
         r_pressed <= 1'b0;
         r_col_idx <= 2'd0;
         r_row_idx <= 2'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bad     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_bad  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_loc.valid) begin
                     r_col_idx <= w_loc.col;
                     r_row_idx <= w_loc.row;
                     r_busy    <= 1'b1;
                     r_state   <= ST_SYNC;
                  end else begin
                     r_bad <= 1'b1;
                  end
               end
            end
            ST_SYNC: begin
               if (w_scan_tick) begin
                  r_pressed <= 1'b1;
                  r_cnt     <= 8'd0;
                  r_state   <= ST_PRESS;
               end
            end
            ST_PRESS: begin
               if (w_scan_tick) begin
                  if (w_cnt_next == c_HOLD_SCANS) begin
                     r_pressed <= 1'b0;
                     r_cnt     <= 8'd0;
                     r_state   <= ST_RELEASE;
                  end else begin
                     r_cnt <= w_cnt_next;
                  end
               end
            end
            ST_RELEASE: begin
               // done is seen while still busy; ready returns on the following cycle
               if (r_done) begin
                  r_busy  <= 1'b0;
                  r_cnt   <= 8'd0;
                  r_state <= ST_IDLE;
               end else if (w_scan_tick) begin
                  if (w_cnt_next == c_RELEASE_SCANS) begin
                     r_done <= 1'b1;
                  end else begin
                     r_cnt <= w_cnt_next;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign key_ready = ~r_busy;
   assign busy      = r_busy;
   assign done      = r_done;
   assign bad_key   = r_bad;

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
// ----------------------------------------------------------------------------
// tb_keypad_emulator : random key commands against a free-running scanner model
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keypad_emulator;

   localparam int HOLD = 2;
   localparam int REL  = 2;

   logic       clk        = 1'b0;
   logic       reset      = 1'b0;
   logic [3:0] auto_col   = 4'hF;
   logic [3:0] manual_col = 4'hF;
   logic       scan_auto  = 1'b1;
   wire  [3:0] column     = scan_auto ? auto_col : manual_col;
   logic [3:0] row;
   logic [3:0] key_code   = 4'h0;
   logic       key_valid  = 1'b0;
   logic       key_ready;
   logic       busy;
   logic       done;
   logic       bad_key;

   always #5 clk = ~clk;

   keypad_emulator #(.HOLD_SCANS(HOLD), .RELEASE_SCANS(REL)) dut (
      .clk       (clk),
      .reset     (reset),
      .column    (column),
      .row       (row),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .busy      (busy),
      .done      (done),
      .bad_key   (bad_key)
   );

   // Physical pad layout, kp[column][row]; F marks a position with no key
   logic [3:0] kp [4][4] = '{
      '{4'h1, 4'h4, 4'h7, 4'h0},
      '{4'h2, 4'h5, 4'h8, 4'hF},
      '{4'h3, 4'h6, 4'h9, 4'hE},
      '{4'hA, 4'hF, 4'hC, 4'hF}
   };

   typedef struct packed {
      logic       bad;
      logic [3:0] code;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_mapped(input logic [3:0] c);
      bit m = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (c != 4'hF && kp[i][j] == c) m = 1'b1;
      return m;
   endfunction

   // Scanner model: walks the four columns with random dwell, occasional
   // multi-low glitches, then one or two idle slots
   initial begin
      forever begin
         for (int c = 0; c < 4; c++) begin
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               auto_col = 4'(~(4'b0001 << c));
            end
            if ($urandom_range(0, 7) == 0) begin
               @(negedge clk);
               auto_col = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'b0101;
            end
         end
         repeat ($urandom_range(1, 2)) begin
            @(negedge clk);
            auto_col = 4'hF;
         end
      end
   end

   // Monitor: decodes what the scanner would read and pops the scoreboard on done/bad_key
   initial begin
      logic [3:0] prev_col;
      logic [3:0] got;
      int press_scans, rel_scans, cb, rb, exp_kind;
      bit seen, prev_done;
      prev_col = 4'hF; press_scans = 0; rel_scans = 0; seen = 0; prev_done = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!mon_en) begin
            prev_col = column; press_scans = 0; rel_scans = 0; seen = 0; prev_done = 0;
            continue;
         end
         if (row != 4'hF) begin
            cb = 0; rb = 0;
            for (int i = 0; i < 4; i++) begin
               if (!column[i]) cb = i;
               if (!row[i])    rb = i;
            end
            check("col_onehot_when_row_active", $countones(~column), 1);
            check("row_onehot", $countones(~row), 1);
            got = kp[cb][rb];
            check("row_key", got, (sb.size() > 0 && !sb[0].bad) ? sb[0].code : 5'h10);
            seen = 1;
         end
         if (column == 4'hF && prev_col != 4'hF) begin
            if (seen) press_scans++;
            else if (press_scans > 0) rel_scans++;
            seen = 0;
         end
         prev_col = column;
         if (prev_done) check("ready_after_done", {key_ready, busy}, 2'b10);
         if (done) begin
            exp_kind = (sb.size() == 0) ? 2 : int'(sb[0].bad);
            check("done_kind", 0, exp_kind);
            check("hold_scans", press_scans, HOLD);
            check("release_scans", rel_scans, REL);
            check("ready_during_done", key_ready, 0);
            if (sb.size() > 0) void'(sb.pop_front());
            press_scans = 0; rel_scans = 0;
         end
         if (bad_key) begin
            exp_kind = (sb.size() == 0) ? 2 : int'(sb[0].bad);
            check("bad_kind", 1, exp_kind);
            check("bad_no_press", press_scans, 0);
            check("ready_with_bad", key_ready, 1);
            if (sb.size() > 0) void'(sb.pop_front());
         end
         prev_done = done;
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input logic [3:0] code, input bit hold);
      int n = 0;
      key_code  = code;
      key_valid = 1'b1;
      while (!key_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait_bounded", int'(n < 5000), 1);
      @(posedge clk);
      sb.push_back('{bad: !is_mapped(code), code: code});
      @(negedge clk);
      if (!hold) begin
         key_valid = 1'b0;
         key_code  = 4'($urandom);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int  n, dcount;
      bit  h;
      repeat (3) @(negedge clk);
      check("rst_row", row, 4'hF);
      check("rst_ready", key_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bad", bad_key, 0);
      reset  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Valid held high across back-to-back identical keys
      issue(4'h1, 1'b1);
      issue(4'h1, 1'b1);
      issue(4'hE, 1'b0);
      issue(4'hB, 1'b0);

      for (int k = 0; k < 30; k++) begin
         h = ($urandom_range(0, 3) == 0) && (k != 29);
         issue(4'($urandom_range(0, 15)), h);
         if (!h) begin
            repeat ($urandom_range(0, 5)) begin
               @(negedge clk);
               key_code = 4'($urandom);
            end
         end
      end

      n = 0;
      while (sb.size() > 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", sb.size(), 0);

      // Stalled scanner: column frozen on a non-idle value
      mon_en     = 1'b0;
      manual_col = 4'hF;
      scan_auto  = 1'b0;
      repeat (3) @(negedge clk);
      manual_col = 4'b1101;
      @(negedge clk);
      issue(4'h0, 1'b0);
      dcount = 0;
      repeat (1000) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("stall_busy", busy, 1);
      check("stall_no_done", dcount, 0);
      check("stall_row", row, 4'hF);

      // One idle slot starts the press of key 0 (column 0, row 3)
      manual_col = 4'hF;
      @(negedge clk);
      manual_col = 4'b1110;
      #1 check("press_row_match", row, 4'b0111);
      manual_col = 4'b0011;
      #1 check("press_row_multi_low", row, 4'hF);
      manual_col = 4'b0111;
      #1 check("press_row_other_col", row, 4'hF);
      manual_col = 4'b1110;
      #1 check("press_row_match_again", row, 4'b0111);

      #1 reset = 1'b0;
      #1 check("async_reset_row", row, 4'hF);
      check("async_reset_ready", key_ready, 1);
      check("async_reset_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 check("post_reset_ready_busy", {key_ready, busy}, 2'b10);
      check("post_reset_row", row, 4'hF);
      sb.delete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
